popcount_sched: RTL

Round-robin scheduler that shares one 8-bit population-count datapath among NREQ requesters. Each requester submits a word of NBYTES bytes. The block grants one requester and streams that word through the shared popcount one byte per cycle, accumulating the total. It then returns the count and the requester ID on a valid/ready result port. It sits between the requesting clients and the combinational 8-bit bit-count unit, and is the only driver of that unit.

---
 rtl/popcount_sched.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/popcount_sched.sv
`default_nettype none
// ============================================================================
//  Module   : popcount_sched
//  Purpose  : Round-robin scheduler that shares one 8-bit popcount datapath
//             among NREQ requesters. A granted word is streamed through the
//             popcount one byte per cycle. The total and the requester ID are
//             then returned on a valid/ready result port.
//  Revision : 1.0 - initial release
// ============================================================================
module popcount_sched #(
  parameter int NREQ   = 4,
  parameter int NBYTES = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NREQ-1:0]                       req_valid,
  input  logic [NREQ*8*NBYTES-1:0]              req_data,
  output logic [NREQ-1:0]                       req_ready,
  output logic                                  res_valid,
  input  logic                                  res_ready,
  output logic [$clog2(8*NBYTES+1)-1:0]         res_count,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] res_id,
  output logic                                  busy
);

  localparam int W     = 8 * NBYTES;
  localparam int RES_W = $clog2(W + 1);
  localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] COUNT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_q,   state_d;
  logic [W-1:0]     word_q,    word_d;
  logic [ID_W-1:0]  id_q,      id_d;
  logic [ID_W-1:0]  last_id_q, last_id_d;
  logic [IDX_W-1:0] idx_q,     idx_d;
  logic [RES_W-1:0] acc_q,     acc_d;

  logic             grant_found;
  logic [ID_W-1:0]  grant_id;
  logic [W-1:0]     grant_word;
  logic [7:0]       cur_byte;
  logic [3:0]       cur_pc;

  // The shared 8-bit bit-count unit.
  function automatic logic [3:0] popcount8(input logic [7:0] b);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, b[i]};
    end
    return n;
  endfunction

  // Round-robin pick: scan from last_id+1 upward with wrap, first valid wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!grant_found && req_valid[i] &&
            (((int'(last_id_q) + k) % NREQ) == i)) begin
          grant_found = 1'b1;
          grant_id    = ID_W'(i);
        end
      end
    end
  end

  // Grant strobe and the word slice of the chosen requester.
  always_comb begin
    req_ready  = '0;
    grant_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        grant_word = req_data[i*W +: W];
        req_ready[i] = (state_q == IDLE) && grant_found && !rst;
      end
    end
  end

  // Byte presented to the popcount unit this cycle.
  always_comb begin
    cur_byte = '0;
    for (int b = 0; b < NBYTES; b++) begin
      if (idx_q == IDX_W'(b)) begin
        cur_byte = word_q[b*8 +: 8];
      end
    end
    cur_pc = popcount8(cur_byte);
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    id_d      = id_q;
    last_id_d = last_id_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          // The word is private from here on; later req_data changes are ignored.
          word_d  = grant_word;
          id_d    = grant_id;
          idx_d   = '0;
          acc_d   = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        acc_d = acc_q + RES_W'(cur_pc);
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(NBYTES - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          // The requester just served drops to lowest priority.
          last_id_d = id_q;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset discards any job in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      word_q    <= '0;
      id_q      <= '0;
      last_id_q <= ID_W'(NREQ - 1);
      idx_q     <= '0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      id_q      <= id_d;
      last_id_q <= last_id_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
    end
  end

  // Result outputs are forced to zero outside DONE so idle values match reset.
  always_comb begin
    res_valid = (state_q == DONE);
    res_count = (state_q == DONE) ? acc_q : '0;
    res_id    = (state_q == DONE) ? id_q  : '0;
    busy      = (state_q != IDLE);
  end

endmodule
`default_nettype wire
